// File: rtl/fir_tap_sequencer.sv
// Sequential FIR feeder: converts ADC samples, steps taps through an external multiplier.
// Optional macro FIR_SAT_EN clamps the output instead of wrapping it.
module fir_tap_sequencer #(
    parameter int D_W    = 16,
    parameter int ADC_W  = 12,
    parameter int N_TAPS = 8,
    parameter int ACC_W  = 20
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      adc_valid,
    input  logic [ADC_W-1:0]          adc_data,
    output logic                      adc_ready,
    input  logic                      coef_we,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr,
    input  logic [D_W-1:0]            coef_data,
    output logic                      dsp_CE,
    output logic [D_W-1:0]            dsp_A,
    output logic [D_W-1:0]            dsp_B,
    input  logic [D_W-1:0]            dsp_prod,
    output logic [D_W-1:0]            fir_out,
    output logic                      fir_valid,
    output logic                      overrun
);

    localparam int AW = $clog2(N_TAPS);
    localparam int SH = D_W - 1 - ADC_W;
    localparam logic [AW-1:0] LAST = AW'(N_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [AW-1:0]      idx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [D_W-1:0]     result;
    logic [D_W-1:0]     dline [N_TAPS];
    logic [D_W-1:0]     coef  [N_TAPS];
    logic [ADC_W-1:0]   centered;
    logic [D_W-1:0]     sample;

    // Flipping the MSB of offset-binary gives two's complement directly.
    assign centered = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
    assign sample   = {{(D_W-ADC_W){centered[ADC_W-1]}}, centered} << SH;

    assign acc_next = acc + {{(ACC_W-D_W){dsp_prod[D_W-1]}}, dsp_prod};

`ifdef FIR_SAT_EN
    logic [ACC_W-D_W:0] hi;
    assign hi = acc_next[ACC_W-1:D_W-1];

    always_comb begin
        result = acc_next[D_W-1:0];
        if (!((&hi) || !(|hi))) begin
            result = acc_next[ACC_W-1] ? {1'b1, {(D_W-1){1'b0}}}
                                       : {1'b0, {(D_W-1){1'b1}}};
        end
    end
`else
    assign result = acc_next[D_W-1:0];
`endif

    assign adc_ready = (state == IDLE);
    assign dsp_CE    = (state == RUN);
    assign dsp_A     = (state == RUN) ? coef[idx]  : '0;
    assign dsp_B     = (state == RUN) ? dline[idx] : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            fir_out   <= '0;
            fir_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                dline[k] <= '0;
                coef[k]  <= '0;
            end
        end else begin
            fir_valid <= 1'b0;
            if (coef_we) begin
                coef[coef_addr] <= coef_data;
            end
            if (adc_valid && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (adc_valid) begin
                        dline[0] <= sample;
                        for (int k = 1; k < N_TAPS; k++) begin
                            dline[k] <= dline[k-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    // Result is registered on the last tap so it appears in DONE.
                    if (idx == LAST) begin
                        fir_out   <= result;
                        fir_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
